// File: rtl/rtr_input_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rtr_input_unit: router input port (flit FIFO, XY route, wormhole request) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rtr_input_unit #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int NR     = 5,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              IN_VALID,
  input  logic [FLIT_W-1:0] IN_FLIT,
  output logic [NR-1:0]     REQ,
  input  logic [NR-1:0]     GRT,
  output logic [FLIT_W-1:0] OUT_FLIT,
  output logic              CREDIT_OUT,
  output logic              OVF,
  output logic              ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    c_ptr_one = (AW+1)'(1);
  localparam logic [X_W-1:0] c_cur_x   = X_W'(CUR_X);
  localparam logic [Y_W-1:0] c_cur_y   = Y_W'(CUR_Y);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  state_t            r_state;
  state_t            w_next;
  logic [NR-1:0]     r_port_sel;
  logic              r_credit;
  logic              r_ovf;
  logic              r_err;

  logic              w_empty;
  logic              w_full;
  logic [FLIT_W-1:0] w_head;
  logic [1:0]        w_type;
  logic [X_W-1:0]    w_dx;
  logic [Y_W-1:0]    w_dy;
  logic [NR-1:0]     w_route;
  logic [NR-1:0]     w_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_load;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_type  = w_head[FLIT_W-1:FLIT_W-2];
  assign w_dx    = w_head[X_W+Y_W-1:Y_W];
  assign w_dy    = w_head[Y_W-1:0];
  assign w_push  = IN_VALID && (!w_full || w_pop);

  always_comb begin
    w_route = '0;
    if (w_dx > c_cur_x)      w_route[2] = 1'b1;
    else if (w_dx < c_cur_x) w_route[4] = 1'b1;
    else if (w_dy > c_cur_y) w_route[1] = 1'b1;
    else if (w_dy < c_cur_y) w_route[3] = 1'b1;
    else                     w_route[0] = 1'b1;
  end

  // Type bit 1 marks a packet start (HEAD/HEADTAIL), bit 0 a packet end (TAIL/HEADTAIL).
  always_comb begin
    w_next = r_state;
    w_req  = '0;
    w_pop  = 1'b0;
    w_drop = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_type[1]) begin
            w_load = 1'b1;
            w_next = S_ACTIVE;
          end else begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (!w_empty) w_req = r_port_sel;
        if ((w_req & GRT) != '0) begin
          w_pop = 1'b1;
          if (w_type[0]) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_state    <= S_IDLE;
      r_port_sel <= '0;
      r_credit   <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_credit <= w_pop;
      r_err    <= w_drop;
      if (w_load) r_port_sel <= w_route;
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      if (IN_VALID && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= IN_FLIT;
  end

  assign REQ        = w_req;
  assign OUT_FLIT   = w_head;
  assign CREDIT_OUT = r_credit;
  assign OVF        = r_ovf;
  assign ERR        = r_err;

endmodule
`default_nettype wire

// File: doc/rtr_input_unit.md
Name: rtr_input_unit

Overview:
- Router input port that sits upstream of the output-port round-robin arbiters.
- Buffers incoming flits and decodes the destination of each head flit with XY routing.
- Drives a one-hot request vector to the arbiters and holds it, wormhole-style, until the tail flit has been granted.
- Returns one credit upstream for every flit it dequeues.

Parameters:
- FLIT_W, 32: flit width. Bits [FLIT_W-1:FLIT_W-2] are the flit type: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEADTAIL.
- DEPTH, 4: FIFO depth in flits. Must be a power of 2, at least 2.
- NR, 5: number of output ports. Bit 0 Local, 1 North, 2 East, 3 South, 4 West.
- X_W, 2: width of the destination X field, which occupies head bits [X_W+Y_W-1:Y_W].
- Y_W, 2: width of the destination Y field, which occupies head bits [Y_W-1:0].
- CUR_X, 0: this router's X coordinate.
- CUR_Y, 0: this router's Y coordinate.

Ports:
- CLK  in  1  clock. Single clock domain.
- RSTn  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  a flit is present on IN_FLIT this cycle.
- IN_FLIT  in  FLIT_W  incoming flit.
- REQ  out  NR  one-hot request to the output arbiters, or all zero.
- GRT  in  NR  grant from the arbiters. A transfer occurs in any cycle where (REQ & GRT) != 0.
- OUT_FLIT  out  FLIT_W  the FIFO head flit. Meaningful only while REQ != 0.
- CREDIT_OUT  out  1  one-cycle pulse, one per dequeued flit.
- OVF  out  1  sticky flag: a push was attempted while the FIFO was full.
- ERR  out  1  one-cycle pulse: a non-head flit was dropped while in IDLE.

Behaviour:
- Reset, asynchronous while RSTn=0:
  - FIFO is empty, pointers are 0, state is IDLE, port_sel=0.
  - REQ=0, CREDIT_OUT=0, OVF=0, ERR=0.
  - Reset mid-packet discards all buffered flits. No credits are returned for them.
- FIFO:
  - Circular buffer with pointers one bit wider than log2(DEPTH); full/empty are decided by the MSB compare.
  - Push occurs when IN_VALID=1 and (not full, or a pop happens in the same cycle).
  - Push while full with no pop: the flit is dropped and OVF is set; OVF clears only on reset.
  - Simultaneous push and pop leaves the count unchanged.
  - OUT_FLIT is driven combinationally from the head entry.
- Routing, computed combinationally on the head flit:
  - dx>CUR_X selects E.
  - dx<CUR_X selects W.
  - Otherwise dy>CUR_Y selects N, dy<CUR_Y selects S, and dy==CUR_Y selects Local.
  - Comparisons are unsigned.
- FSM, two states:
  - IDLE, FIFO empty: stay in IDLE. REQ=0.
  - IDLE, head type is HEAD or HEADTAIL: register the routed one-hot vector into port_sel, then go to ACTIVE. REQ stays 0 in this cycle.
  - IDLE, head type is BODY or TAIL: pop and drop the flit, pulse ERR the next cycle, and return its credit as normal. Stay in IDLE.
  - ACTIVE: REQ = port_sel when the FIFO is non-empty, otherwise REQ = 0. This is a bubble; port_sel is retained.
  - ACTIVE, (REQ & GRT) != 0: pop the flit. If it was TAIL or HEADTAIL, go to IDLE. Otherwise stay in ACTIVE.
  - REQ remains asserted, and OUT_FLIT stable, until granted. Grants on bits other than port_sel are ignored.
- Latency:
  - A flit pushed into an empty FIFO at edge t appears at the head in cycle t+1.
  - The FSM enters ACTIVE at edge t+2; REQ is high from cycle t+2.
  - Body flits that are already buffered request back-to-back, so one flit can transfer per cycle.
- Credits:
  - CREDIT_OUT is registered: it pulses in the cycle after each pop.
  - No more than one pulse per cycle.
  - Total credits returned equal total pops.

Test Plan:
- Reset/idle: hold RSTn=0, then release with no input -> REQ=0, CREDIT_OUT=0, OVF=0, ERR=0 for 10 cycles.
- Local HEADTAIL: CUR=(1,1), push type 11 with dest (1,1) at edge 0, GRT=5'b00001 held -> REQ=5'b00001 in cycle 2; pop at edge 3, CREDIT_OUT=1 in cycle 3, state IDLE.
- Wormhole east with backpressure: push HEAD dest (3,0), BODY, BODY, TAIL at CUR=(1,1) with GRT=0 for 6 cycles -> REQ=5'b00100 held and OUT_FLIT = the head flit. Then GRT=5'b00100 -> four pops on consecutive edges, four CREDIT_OUT pulses, REQ=0 after the tail.
- XY order: CUR=(1,1), dest (1,3) -> N (5'b00010); dest (0,3) -> W (5'b10000); dest (1,0) -> S (5'b01000).
- Overflow and simultaneous push/pop: DEPTH=4, fill 4 flits with GRT=0, push a 5th -> OVF=1 and the flit is dropped. Then push while granted -> count stays 4 and the flit is accepted.
- Orphan flit and reset mid-packet: BODY at head in IDLE -> ERR pulse, CREDIT_OUT pulse, no REQ. Assert RSTn=0 mid-packet in ACTIVE -> REQ=0 immediately, FIFO empty.
